// File: rtl/dmem_bus.sv
// Data memory behind the MEM stage: valid/ready request/response, byte/half/word
// accesses with sign/zero-extended loads, programmable wait states and error flag.
module dmem_bus #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW  = $clog2(DEPTH);
    localparam logic [3:0] LAT = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, uns_q, err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, rdata_q;

    logic [31:0] mem [DEPTH] = '{default: '0};

    logic        accept, enter_resp;
    logic        c_we, c_uns, c_err;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata;
    logic [AW-1:0] c_idx;
    logic [31:0] c_word, c_wmask, c_wlane, c_load;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LAT == 4'd0) begin
                        state_d    = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = LAT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d    = S_RESP;
                    enter_resp = !rst;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // With zero latency the access commits on the accept edge, so use the live request.
    assign c_we    = (state_q == S_IDLE) ? req_we       : we_q;
    assign c_uns   = (state_q == S_IDLE) ? req_unsigned : uns_q;
    assign c_size  = (state_q == S_IDLE) ? req_size     : size_q;
    assign c_addr  = (state_q == S_IDLE) ? req_addr     : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? req_wdata    : wdata_q;

    assign c_err = (c_size == 2'b11)
                || (c_size == 2'b01 && c_addr[0])
                || (c_size == 2'b10 && c_addr[1:0] != 2'b00)
                || (c_addr[31:2] >= 30'(DEPTH));

    assign c_idx  = c_addr[AW+1:2];
    assign c_word = mem[c_idx];
    assign ld_b   = c_word[{c_addr[1:0], 3'b000} +: 8];
    assign ld_h   = c_addr[1] ? c_word[31:16] : c_word[15:0];

    always_comb begin
        c_wmask = '0;
        c_wlane = c_wdata;
        c_load  = c_word;
        case (c_size)
            2'b00: begin
                c_wmask = 32'h0000_00FF << {c_addr[1:0], 3'b000};
                c_wlane = {4{c_wdata[7:0]}};
                c_load  = c_uns ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
            end
            2'b01: begin
                c_wmask = c_addr[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                c_wlane = {2{c_wdata[15:0]}};
                c_load  = c_uns ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
            end
            2'b10:   c_wmask = 32'hFFFF_FFFF;
            default: c_wmask = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (enter_resp) begin
                err_q   <= c_err;
                rdata_q <= (c_err || c_we) ? 32'h0 : c_load;
            end else if (state_q == S_RESP && rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= '0;
            end
        end
    end

    // Contents survive reset; a store still in WAIT never reaches enter_resp.
    always_ff @(posedge clk) begin
        if (enter_resp && c_we && !c_err) begin
            mem[c_idx] <= (c_word & ~c_wmask) | (c_wlane & c_wmask);
        end
    end

endmodule

// File: doc/dmem_bus.md
# dmem_bus

Parametrised data memory with a valid/ready request/response interface, byte/half/word access sizes, sign- or zero-extended loads, a configurable wait-state count and error reporting. It is the next generation of the pipeline CPU's single-cycle word-only data memory. It sits behind the MEM stage, where the stage stalls on `req_ready`/`rsp_valid`. One request is outstanding at a time.

## Interface
- `DEPTH`, default 256: number of 32-bit words; a power of two, ≥4.
- `LATENCY`, default 1: wait cycles between acceptance and response; allowed range 0–15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, taken from the low-order bits.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: load data. It is 0 for stores and for errors.
- `rsp_err` out 1: the request was misaligned, out of range, or used an illegal size.

## Operation
- Storage is `DEPTH` × 32, little-endian. Word index = `req_addr[31:2]`. Contents are zero at time 0 and are not cleared by `rst`.
- FSM states:
  - IDLE: `req_ready` = 1.
  - WAIT: counts `LATENCY` cycles.
  - RESP: `rsp_valid` = 1.
- FSM transitions:
  - IDLE → WAIT on accept (`req_valid & req_ready`). If `LATENCY` = 0, IDLE → RESP directly.
  - WAIT → RESP when the counter expires.
  - RESP → IDLE on `rsp_ready`.
- On accept, all `req_*` fields are registered. Inputs are don't-care outside the accept cycle.
- Error = any of:
  - `req_size` = 11;
  - half with `addr[0]` = 1;
  - word with `addr[1:0]` ≠ 0;
  - word index ≥ `DEPTH`.
- On error: no write occurs, `rsp_rdata` = 0 and `rsp_err` = 1.
- Store lane selection:
  - byte: writes lane `addr[1:0]` with `wdata[7:0]`;
  - half: writes lanes {`addr[1]`·2, +1} with `wdata[15:0]`;
  - word: writes all lanes.
  - Other lanes are preserved.
- Load data: the selected byte or half is right-justified, then sign- or zero-extended to 32 bits per `req_unsigned`. Word loads ignore `req_unsigned`.
- Write commit and read sampling both happen on the edge that enters RESP. A load therefore observes every earlier store.
- `rsp_rdata` and `rsp_err` are held stable while in RESP. They return to 0 on the edge leaving RESP.
- Reset, at any time:
  - state → IDLE;
  - `rsp_valid`, `rsp_rdata`, `rsp_err` → 0;
  - `req_ready` = 0 while `rst` is high, and 1 in the first cycle after release;
  - an uncommitted store (in WAIT) is discarded;
  - a store already committed in RESP stays in memory.

## Timing
- Accept edge = E0. RESP is entered at edge E0+`LATENCY`. `rsp_valid` is high from the cycle after that edge.
- `LATENCY` = 0: response appears in the cycle immediately after acceptance.
- The response is held for any number of cycles until `rsp_ready`. The handshake completes at the edge where both `rsp_valid` and `rsp_ready` are 1.
- `req_ready` rises in the cycle after the response handshake. There is no combinational path from `rsp_ready` to `req_ready`.
- Best-case throughput: one request per `LATENCY`+2 cycles.
- `req_ready` and `rsp_valid` are never high in the same cycle.
- All outputs are registered or decoded from state only. There are no combinational input→output paths.

## Test plan
- **Reset:** assert `rst` mid-WAIT of a store to 0x10 (`LATENCY` = 3) → the word at 0x10 remains 0. During reset `rsp_valid`/`rsp_err`/`rsp_rdata` = 0 and `req_ready` = 0. After release, `req_ready` = 1 the next cycle.
- **Word round trip, `LATENCY` = 1:**
  - SW 0xDEADBEEF @0x20 → `rsp_valid` in the 2nd cycle after accept, `rsp_err` = 0.
  - LW @0x20 → `rsp_rdata` = 0xDEADBEEF.
- **Byte/half lanes:**
  - SB 0x80 @0x21 over 0xDEADBEEF → word = 0xDEAD80EF.
  - LB @0x21 → 0xFFFFFF80; LBU → 0x00000080.
  - SH 0x1234 @0x22 → word = 0x123480EF.
  - LH @0x22 → 0x00001234.
- **Errors:**
  - LW @0x22 → `rsp_err` = 1, `rdata` = 0.
  - SH @0x23 → error, memory unchanged.
  - `req_size` = 11 → error.
  - LW @(`DEPTH`·4) → error.
- **Backpressure:** hold `rsp_ready` = 0 for 5 cycles → `rsp_valid` and `rsp_rdata` stay stable, `req_ready` = 0 throughout. `req_valid` pulsed during RESP is ignored.
- **`LATENCY` = 0, back-to-back:** issue SW then LW at the same address with `rsp_ready` = 1 → the LW returns the new data. Accepts occur every 2 cycles.
